// File: rtl/pov_pkg.sv
// rtl/pov_pkg.sv - shared state encoding and default timing constants for the POV pixel scheduler
package pov_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_RUN     = 2'd2
    } pov_state_t;

    localparam int unsigned POV_PIXELS_PER_REV = 200;
    localparam int unsigned POV_PERIOD_W       = 28;
    localparam int unsigned POV_MIN_PERIOD     = 32'd1000000;
    localparam int unsigned POV_MAX_PERIOD     = 32'd100000000;

endpackage

// File: rtl/pov_pixel_scheduler_if.sv
// rtl/pov_pixel_scheduler_if.sv - pixel timing bundle from the scheduler to the column renderer
interface pov_pixel_scheduler_if #(
    parameter int unsigned PERIOD_W = 28
);
    logic                pixel_strobe;
    logic [7:0]          column;
    logic                frame_start;
    logic [PERIOD_W-1:0] clocks_per_pixel;
    logic                locked;
    logic                stalled;

    modport master (
        output pixel_strobe, column, frame_start, clocks_per_pixel, locked, stalled
    );

    modport slave (
        input pixel_strobe, column, frame_start, clocks_per_pixel, locked, stalled
    );
endinterface

// File: rtl/pov_period_divider.sv
// rtl/pov_period_divider.sv - restoring divider, one quotient bit per clock, done pulses PERIOD_W clocks after start
module pov_period_divider #(
    parameter int unsigned PERIOD_W = 28
) (
    input  logic                board_clk,
    input  logic                Reset,
    input  logic                start,
    input  logic [PERIOD_W-1:0] dividend,
    input  logic [7:0]          divisor,
    output logic                done,
    output logic [PERIOD_W-1:0] quotient
);
    localparam int unsigned CW = $clog2(PERIOD_W + 1);

    logic [7:0]    rem;
    logic [CW-1:0] bits_left;
    logic          busy;
    logic [8:0]    trial;

    // Remainder stays below the divisor, so the shifted trial value fits in 9 bits.
    assign trial = {rem, quotient[PERIOD_W-1]};

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            rem       <= '0;
            quotient  <= '0;
            bits_left <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem       <= '0;
                quotient  <= dividend;
                bits_left <= CW'(PERIOD_W);
                busy      <= 1'b1;
            end else if (busy) begin
                if (trial >= {1'b0, divisor}) begin
                    rem      <= 8'(trial - {1'b0, divisor});
                    quotient <= {quotient[PERIOD_W-2:0], 1'b1};
                end else begin
                    rem      <= trial[7:0];
                    quotient <= {quotient[PERIOD_W-2:0], 1'b0};
                end
                bits_left <= bits_left - CW'(1);
                if (bits_left == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/pov_pixel_scheduler.sv
// rtl/pov_pixel_scheduler.sv - index-period measurement and pixel slot scheduler; POV_PERIOD_AVG_EN averages consecutive periods
module pov_pixel_scheduler
    import pov_pkg::*;
#(
    parameter int unsigned PIXELS_PER_REV = POV_PIXELS_PER_REV,
    parameter int unsigned PERIOD_W       = POV_PERIOD_W,
    parameter int unsigned MIN_PERIOD     = POV_MIN_PERIOD,
    parameter int unsigned MAX_PERIOD     = POV_MAX_PERIOD,
    parameter int unsigned INDEX_ACT_LOW  = 1
) (
    input  logic                  board_clk,
    input  logic                  Reset,
    input  logic                  enable,
    input  logic                  index_in,
    pov_pixel_scheduler_if.master pix
);
    localparam logic [PERIOD_W-1:0] MIN_P    = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] MAX_P    = PERIOD_W'(MAX_PERIOD);
    localparam logic [7:0]          LAST_COL = 8'(PIXELS_PER_REV - 1);
    localparam logic                IDX_INV  = (INDEX_ACT_LOW != 0);

    pov_state_t          state;
    logic                idx_meta, idx_sync, idx_prev;
    logic                idx_edge, accepted, div_start, div_done;
    logic [PERIOD_W-1:0] period_cnt, period, div_in, div_q, pix_cnt, cpp;
    logic [7:0]          column;
    logic                strobe, frame, locked, stalled;

    // Index is normalised to active-high before the synchroniser so reset idles it at 0.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            idx_meta <= 1'b0;
            idx_sync <= 1'b0;
            idx_prev <= 1'b0;
        end else begin
            idx_meta <= index_in ^ IDX_INV;
            idx_sync <= idx_meta;
            idx_prev <= idx_sync;
        end
    end

    assign idx_edge  = idx_sync & ~idx_prev;
    assign accepted  = enable && idx_edge && (state == ST_IDLE || period_cnt >= MIN_P);
    assign period    = period_cnt + PERIOD_W'(1);
    assign div_start = accepted && (state != ST_IDLE);

`ifdef POV_PERIOD_AVG_EN
    logic [PERIOD_W-1:0] prev_period;
    logic [PERIOD_W:0]   period_sum;

    assign period_sum = {1'b0, prev_period} + {1'b0, period};
    assign div_in     = (state == ST_RUN) ? period_sum[PERIOD_W:1] : period;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset)         prev_period <= '0;
        else if (accepted) prev_period <= period;
    end
`else
    assign div_in = period;
`endif

    pov_period_divider #(.PERIOD_W(PERIOD_W)) u_div (
        .board_clk (board_clk),
        .Reset     (Reset),
        .start     (div_start),
        .dividend  (div_in),
        .divisor   (8'(PIXELS_PER_REV)),
        .done      (div_done),
        .quotient  (div_q)
    );

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            period_cnt <= '0;
            pix_cnt    <= '0;
            column     <= '0;
            strobe     <= 1'b0;
            frame      <= 1'b0;
            cpp        <= '0;
            locked     <= 1'b0;
            stalled    <= 1'b0;
        end else begin
            strobe <= 1'b0;
            frame  <= 1'b0;
            if (accepted)                period_cnt <= '0;
            else if (period_cnt != MAX_P) period_cnt <= period_cnt + PERIOD_W'(1);

            if (!enable) begin
                state   <= ST_IDLE;
                locked  <= 1'b0;
                cpp     <= '0;
                column  <= '0;
                pix_cnt <= '0;
            end else begin
                // Results landing outside RUN belong to an abandoned measurement.
                if (div_done && state == ST_RUN) begin
                    cpp    <= (div_q == '0) ? PERIOD_W'(1) : div_q;
                    locked <= 1'b1;
                end
                if (accepted) begin
                    frame   <= 1'b1;
                    strobe  <= locked;
                    stalled <= 1'b0;
                    column  <= '0;
                    pix_cnt <= '0;
                    state   <= (state == ST_IDLE) ? ST_MEASURE : ST_RUN;
                end else if (state != ST_IDLE && period_cnt == MAX_P) begin
                    state   <= ST_IDLE;
                    stalled <= 1'b1;
                    locked  <= 1'b0;
                end else if (state == ST_RUN && locked && column != LAST_COL) begin
                    if (pix_cnt >= cpp - PERIOD_W'(1)) begin
                        pix_cnt <= '0;
                        column  <= column + 8'd1;
                        strobe  <= 1'b1;
                    end else begin
                        pix_cnt <= pix_cnt + PERIOD_W'(1);
                    end
                end
            end
        end
    end

    assign pix.pixel_strobe     = strobe;
    assign pix.column           = column;
    assign pix.frame_start      = frame;
    assign pix.clocks_per_pixel = cpp;
    assign pix.locked           = locked;
    assign pix.stalled          = stalled;
endmodule
